// File: rtl/packetmem_nbuf.sv
// Packet memory: NUM_BUFS packet RAMs handed snooper -> CPU -> forwarder through index FIFOs.
// Latency: rd_data 1 cycle after an accepted rd_en; a released buffer reaches the next agent 2 edges after the pulse.
// Backpressure: an agent idles (ready low) while its source queue is empty; the snooper stalls when every buffer is in flight.
//
// Ports: snooper_* write side of the buffer held by the snooper (+ done pulse);
//        cpu_* word read port, accept/reject pulses, len_to_cpu of the held buffer;
//        forwarder_* word read port, done pulse, len_to_forwarder; rej_count saturating reject counter.

// Index queue: DEPTH entries of W bits, one pop and up to two pushes per cycle.
// Latency: a pushed index is visible at the head on the next edge; push0 lands ahead of push1.
// Backpressure: none; the caller never pops an empty queue and total indices never exceed DEPTH.
module packetmem_nbuf_idxq #(
    parameter int DEPTH     = 4,
    parameter int W         = 2,
    parameter bit INIT_FULL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push0_vld_i,
    input  logic [W-1:0] push0_dat_i,
    input  logic         push1_vld_i,
    input  logic [W-1:0] push1_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (push0_vld_i && push1_vld_i) wr_ptr_d = nxt(nxt(wr_ptr_q));
        else if (push0_vld_i || push1_vld_i) wr_ptr_d = nxt(wr_ptr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // A full free list starts as 0,1,...,DEPTH-1 so buffer 0 is handed out first.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT_FULL ? W'(i) : '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= INIT_FULL ? CW'(DEPTH) : '0;
        end else begin
            if (push0_vld_i) mem_q[wr_ptr_q] <= push0_dat_i;
            if (push1_vld_i) mem_q[push0_vld_i ? nxt(wr_ptr_q) : wr_ptr_q] <= push1_dat_i;
            wr_ptr_q <= wr_ptr_d;
            if (pop_i) rd_ptr_q <= nxt(rd_ptr_q);
            cnt_q <= cnt_q + CW'(push0_vld_i) + CW'(push1_vld_i) - CW'(pop_i);
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign empty_o    = (cnt_q == '0);
endmodule

module packetmem_nbuf #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_BUFS   = 4,
    parameter int IDX_WIDTH  = $clog2(NUM_BUFS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] snooper_wr_addr,
    input  logic [DATA_WIDTH-1:0] snooper_wr_data,
    input  logic                  snooper_wr_en,
    input  logic                  snooper_done,
    output logic                  ready_for_snooper,
    input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
    input  logic                  cpu_rd_en,
    output logic [DATA_WIDTH-1:0] cpu_rd_data,
    input  logic                  cpu_acc,
    input  logic                  cpu_rej,
    output logic                  ready_for_cpu,
    output logic [ADDR_WIDTH:0]   len_to_cpu,
    input  logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
    input  logic                  forwarder_rd_en,
    output logic [DATA_WIDTH-1:0] forwarder_rd_data,
    input  logic                  forwarder_done,
    output logic                  ready_for_forwarder,
    output logic [ADDR_WIDTH:0]   len_to_forwarder,
    output logic [31:0]           rej_count
);
    logic [DATA_WIDTH-1:0] mem_q [NUM_BUFS][2**ADDR_WIDTH];
    logic [ADDR_WIDTH:0]   len_q [NUM_BUFS];

    logic                 snp_vld_q, cpu_vld_q, fwd_vld_q;
    logic [IDX_WIDTH-1:0] snp_idx_q, cpu_idx_q, fwd_idx_q;
    logic [ADDR_WIDTH:0]  len_cpu_q, len_fwd_q;
    logic [DATA_WIDTH-1:0] cpu_rd_q, fwd_rd_q;
    logic [31:0]          rej_cnt_q;

    logic [IDX_WIDTH-1:0] free_head, tocpu_head, tofwd_head;
    logic                 free_empty, tocpu_empty, tofwd_empty;

    // Pulses only count while the agent actually holds a buffer; accept beats reject.
    logic snp_rel, cpu_fwd, cpu_free, cpu_rel, fwd_rel, snp_wr;
    logic snp_pop, cpu_pop, fwd_pop;
    logic [ADDR_WIDTH:0] wr_len;

    assign snp_rel  = snp_vld_q & snooper_done;
    assign cpu_fwd  = cpu_vld_q & cpu_acc;
    assign cpu_free = cpu_vld_q & cpu_rej & ~cpu_acc;
    assign cpu_rel  = cpu_fwd | cpu_free;
    assign fwd_rel  = fwd_vld_q & forwarder_done;
    assign snp_wr   = snp_vld_q & snooper_wr_en;
    assign wr_len   = {1'b0, snooper_wr_addr} + 1'b1;

    // Acquire only when idle, so a release edge always leaves ready low for a cycle.
    assign snp_pop = ~snp_vld_q & ~free_empty;
    assign cpu_pop = ~cpu_vld_q & ~tocpu_empty;
    assign fwd_pop = ~fwd_vld_q & ~tofwd_empty;

    // CPU index goes in ahead of the forwarder's when both return a buffer together.
    packetmem_nbuf_idxq #(.DEPTH(NUM_BUFS), .W(IDX_WIDTH), .INIT_FULL(1'b1)) u_free (
        .clk(clk), .rst_n(rst_n),
        .push0_vld_i(cpu_free), .push0_dat_i(cpu_idx_q),
        .push1_vld_i(fwd_rel),  .push1_dat_i(fwd_idx_q),
        .pop_i(snp_pop), .head_dat_o(free_head), .empty_o(free_empty)
    );

    packetmem_nbuf_idxq #(.DEPTH(NUM_BUFS), .W(IDX_WIDTH), .INIT_FULL(1'b0)) u_to_cpu (
        .clk(clk), .rst_n(rst_n),
        .push0_vld_i(snp_rel), .push0_dat_i(snp_idx_q),
        .push1_vld_i(1'b0),    .push1_dat_i('0),
        .pop_i(cpu_pop), .head_dat_o(tocpu_head), .empty_o(tocpu_empty)
    );

    packetmem_nbuf_idxq #(.DEPTH(NUM_BUFS), .W(IDX_WIDTH), .INIT_FULL(1'b0)) u_to_fwd (
        .clk(clk), .rst_n(rst_n),
        .push0_vld_i(cpu_fwd), .push0_dat_i(cpu_idx_q),
        .push1_vld_i(1'b0),    .push1_dat_i('0),
        .pop_i(fwd_pop), .head_dat_o(tofwd_head), .empty_o(tofwd_empty)
    );

    // Packet RAM: contents survive reset; the snooper never shares a buffer with a reader.
    always_ff @(posedge clk) begin
        if (snp_wr) mem_q[snp_idx_q][snooper_wr_addr] <= snooper_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BUFS; i++) len_q[i] <= '0;
        end else begin
            if (snp_wr && (wr_len > len_q[snp_idx_q])) len_q[snp_idx_q] <= wr_len;
            if (cpu_free) len_q[cpu_idx_q] <= '0;
            if (fwd_rel)  len_q[fwd_idx_q] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snp_vld_q <= 1'b0;
            snp_idx_q <= '0;
            cpu_vld_q <= 1'b0;
            cpu_idx_q <= '0;
            fwd_vld_q <= 1'b0;
            fwd_idx_q <= '0;
            len_cpu_q <= '0;
            len_fwd_q <= '0;
            cpu_rd_q  <= '0;
            fwd_rd_q  <= '0;
            rej_cnt_q <= '0;
        end else begin
            if (snp_pop) begin
                snp_vld_q <= 1'b1;
                snp_idx_q <= free_head;
            end else if (snp_rel) begin
                snp_vld_q <= 1'b0;
            end

            // The held buffer's length is frozen once it leaves the snooper, so a copy taken at acquire stays exact.
            if (cpu_pop) begin
                cpu_vld_q <= 1'b1;
                cpu_idx_q <= tocpu_head;
                len_cpu_q <= len_q[tocpu_head];
            end else if (cpu_rel) begin
                cpu_vld_q <= 1'b0;
                len_cpu_q <= '0;
            end

            if (fwd_pop) begin
                fwd_vld_q <= 1'b1;
                fwd_idx_q <= tofwd_head;
                len_fwd_q <= len_q[tofwd_head];
            end else if (fwd_rel) begin
                fwd_vld_q <= 1'b0;
                len_fwd_q <= '0;
            end

            // Release clears read data on the same edge ready falls.
            if (cpu_rel) cpu_rd_q <= '0;
            else if (cpu_vld_q && cpu_rd_en) cpu_rd_q <= mem_q[cpu_idx_q][cpu_rd_addr];

            if (fwd_rel) fwd_rd_q <= '0;
            else if (fwd_vld_q && forwarder_rd_en) fwd_rd_q <= mem_q[fwd_idx_q][forwarder_rd_addr];

            if (cpu_free && (rej_cnt_q != '1)) rej_cnt_q <= rej_cnt_q + 32'd1;
        end
    end

    assign ready_for_snooper   = snp_vld_q;
    assign ready_for_cpu       = cpu_vld_q;
    assign ready_for_forwarder = fwd_vld_q;
    assign len_to_cpu          = len_cpu_q;
    assign len_to_forwarder    = len_fwd_q;
    assign cpu_rd_data         = cpu_rd_q;
    assign forwarder_rd_data   = fwd_rd_q;
    assign rej_count           = rej_cnt_q;
endmodule

// File: tb/tb_packetmem_nbuf.sv
// Bench for packetmem_nbuf: directed packets through snooper, CPU and forwarder.
// Expected lengths and read words are queued as stimulus is issued; a negedge monitor
// pops them when ready rises or a read completes. Direct checks cover timing and reset.
module tb_packetmem_nbuf;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int NB = 4;
    localparam int LW = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] snooper_wr_addr = '0;
    logic [DW-1:0] snooper_wr_data = '0;
    logic          snooper_wr_en = 1'b0;
    logic          snooper_done = 1'b0;
    logic          ready_for_snooper;
    logic [AW-1:0] cpu_rd_addr = '0;
    logic          cpu_rd_en = 1'b0;
    logic [DW-1:0] cpu_rd_data;
    logic          cpu_acc = 1'b0;
    logic          cpu_rej = 1'b0;
    logic          ready_for_cpu;
    logic [LW-1:0] len_to_cpu;
    logic [AW-1:0] forwarder_rd_addr = '0;
    logic          forwarder_rd_en = 1'b0;
    logic [DW-1:0] forwarder_rd_data;
    logic          forwarder_done = 1'b0;
    logic          ready_for_forwarder;
    logic [LW-1:0] len_to_forwarder;
    logic [31:0]   rej_count;

    always #5 clk = ~clk;

    packetmem_nbuf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BUFS(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .snooper_wr_addr(snooper_wr_addr), .snooper_wr_data(snooper_wr_data),
        .snooper_wr_en(snooper_wr_en), .snooper_done(snooper_done),
        .ready_for_snooper(ready_for_snooper),
        .cpu_rd_addr(cpu_rd_addr), .cpu_rd_en(cpu_rd_en), .cpu_rd_data(cpu_rd_data),
        .cpu_acc(cpu_acc), .cpu_rej(cpu_rej), .ready_for_cpu(ready_for_cpu),
        .len_to_cpu(len_to_cpu),
        .forwarder_rd_addr(forwarder_rd_addr), .forwarder_rd_en(forwarder_rd_en),
        .forwarder_rd_data(forwarder_rd_data), .forwarder_done(forwarder_done),
        .ready_for_forwarder(ready_for_forwarder), .len_to_forwarder(len_to_forwarder),
        .rej_count(rej_count)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [LW-1:0] cpu_len_q [$];
    logic [LW-1:0] fwd_len_q [$];
    logic [DW-1:0] cpu_rd_q  [$];
    logic [DW-1:0] fwd_rd_q  [$];

    // Packet p, word a carries a tag that identifies both.
    function automatic logic [DW-1:0] pat(input int p, input int a);
        return 64'hDA7A_0000_0000_0000 | (64'(p) << 16) | 64'(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_unexpected(input string name, input logic [63:0] act);
        n_vec++;
        n_bad++;
        $display("FAIL %s: event with nothing expected, got 0x%0h, expected no event, at %0t", name, act, $time);
    endtask

    // Monitor: rising ready pops an expected length, a completed read pops an expected word.
    logic cpu_rdy_prev = 1'b0, fwd_rdy_prev = 1'b0;
    logic cpu_rd_pend = 1'b0, fwd_rd_pend = 1'b0;

    always @(negedge clk) begin
        if (cpu_rd_pend) begin
            if (cpu_rd_q.size() > 0) chk("cpu_rd_data", cpu_rd_data, cpu_rd_q.pop_front());
            else note_unexpected("cpu_rd_data", cpu_rd_data);
        end
        if (fwd_rd_pend) begin
            if (fwd_rd_q.size() > 0) chk("fwd_rd_data", forwarder_rd_data, fwd_rd_q.pop_front());
            else note_unexpected("fwd_rd_data", forwarder_rd_data);
        end
        if (ready_for_cpu && !cpu_rdy_prev) begin
            if (cpu_len_q.size() > 0) chk("len_to_cpu", len_to_cpu, cpu_len_q.pop_front());
            else note_unexpected("len_to_cpu", len_to_cpu);
        end
        if (ready_for_forwarder && !fwd_rdy_prev) begin
            if (fwd_len_q.size() > 0) chk("len_to_fwd", len_to_forwarder, fwd_len_q.pop_front());
            else note_unexpected("len_to_fwd", len_to_forwarder);
        end
        cpu_rd_pend  <= rst_n && cpu_rd_en && ready_for_cpu;
        fwd_rd_pend  <= rst_n && forwarder_rd_en && ready_for_forwarder;
        cpu_rdy_prev <= ready_for_cpu;
        fwd_rdy_prev <= ready_for_forwarder;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int w);
        case (w)
            0:       return ready_for_snooper;
            1:       return ready_for_cpu;
            default: return ready_for_forwarder;
        endcase
    endfunction

    task automatic wait_rdy(input string name, input int w);
        int n = 0;
        while (rdy(w) !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        chk(name, 64'(rdy(w)), 64'd1);
    endtask

    // Writes words a0..a1 (optionally highest address first), then pulses done.
    task automatic snp_pkt(input int p, input int a0, input int a1, input bit desc, input int exp_len);
        wait_rdy("snp_ready", 0);
        for (int k = 0; k <= a1 - a0; k++) begin
            int a;
            a = desc ? a1 - k : a0 + k;
            snooper_wr_en   = 1'b1;
            snooper_wr_addr = AW'(a);
            snooper_wr_data = pat(p, a);
            cyc();
        end
        snooper_wr_en = 1'b0;
        snooper_done  = 1'b1;
        cpu_len_q.push_back(LW'(exp_len));
        cyc();
        snooper_done = 1'b0;
    endtask

    task automatic cpu_read(input int a, input logic [DW-1:0] exp);
        cpu_rd_en   = 1'b1;
        cpu_rd_addr = AW'(a);
        cpu_rd_q.push_back(exp);
        cyc();
        cpu_rd_en = 1'b0;
    endtask

    task automatic fwd_read(input int a, input logic [DW-1:0] exp);
        forwarder_rd_en   = 1'b1;
        forwarder_rd_addr = AW'(a);
        fwd_rd_q.push_back(exp);
        cyc();
        forwarder_rd_en = 1'b0;
    endtask

    task automatic cpu_accept(input int exp_len);
        cpu_acc = 1'b1;
        fwd_len_q.push_back(LW'(exp_len));
        cyc();
        cpu_acc = 1'b0;
    endtask

    task automatic cpu_reject();
        cpu_rej = 1'b1;
        cyc();
        cpu_rej = 1'b0;
    endtask

    task automatic fwd_release();
        forwarder_done = 1'b1;
        cyc();
        forwarder_done = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy_snp"}, 64'(ready_for_snooper), 64'd0);
        chk({tag, "_rdy_cpu"}, 64'(ready_for_cpu), 64'd0);
        chk({tag, "_rdy_fwd"}, 64'(ready_for_forwarder), 64'd0);
        chk({tag, "_len_cpu"}, 64'(len_to_cpu), 64'd0);
        chk({tag, "_len_fwd"}, 64'(len_to_forwarder), 64'd0);
        chk({tag, "_rd_cpu"}, cpu_rd_data, 64'd0);
        chk({tag, "_rd_fwd"}, forwarder_rd_data, 64'd0);
        chk({tag, "_rej"}, 64'(rej_count), 64'd0);
    endtask

    task automatic release_and_check(input string tag);
        rst_n = 1'b1;
        chk({tag, "_snp_before_edge"}, 64'(ready_for_snooper), 64'd0);
        cyc();
        chk({tag, "_snp_cycle1"}, 64'(ready_for_snooper), 64'd1);
        chk({tag, "_cpu_cycle1"}, 64'(ready_for_cpu), 64'd0);
        chk({tag, "_fwd_cycle1"}, 64'(ready_for_forwarder), 64'd0);
        chk({tag, "_rej_cycle1"}, 64'(rej_count), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and first acquire of buffer 0.
        repeat (3) cyc();
        chk_all_zero("reset");
        release_and_check("rel1");

        // One 6-word packet: CPU ready 2 cycles after done, length 6, word 3 reads back.
        snp_pkt(0, 0, 5, 1'b0, 6);
        chk("cpu_not_yet", 64'(ready_for_cpu), 64'd0);
        chk("snp_released", 64'(ready_for_snooper), 64'd0);
        cyc();
        chk("cpu_ready_2cyc", 64'(ready_for_cpu), 64'd1);
        chk("snp_reacquired", 64'(ready_for_snooper), 64'd1);
        cpu_read(3, pat(0, 3));

        // Two more packets queue up behind the CPU; accept, reject, accept.
        snp_pkt(1, 0, 2, 1'b0, 3);
        snp_pkt(2, 0, 4, 1'b0, 5);
        cpu_accept(6);
        wait_rdy("cpu_ready_p1", 1);
        cpu_read(2, pat(1, 2));
        cpu_reject();
        chk("rej_after_p1", 64'(rej_count), 64'd1);
        wait_rdy("cpu_ready_p2", 1);
        cpu_read(4, pat(2, 4));
        cpu_accept(5);
        wait_rdy("fwd_ready_p0", 2);
        fwd_read(3, pat(0, 3));
        fwd_release();
        wait_rdy("fwd_ready_p2", 2);
        fwd_read(0, pat(2, 0));
        fwd_release();
        chk("rej_after_fwd", 64'(rej_count), 64'd1);

        // Forwarder stalls on packet 3; snooper fills the rest until no buffer is free.
        snp_pkt(3, 0, 6, 1'b1, 7);
        wait_rdy("cpu_ready_p3", 1);
        cpu_accept(7);
        wait_rdy("fwd_ready_p3", 2);
        for (int p = 4; p <= 6; p++) begin
            snp_pkt(p, 0, p - 3, 1'b0, p - 2);
            wait_rdy("cpu_ready_fill", 1);
            cpu_accept(p - 2);
        end
        repeat (3) cyc();
        chk("snp_starved", 64'(ready_for_snooper), 64'd0);
        fwd_release();
        chk("snp_still_low", 64'(ready_for_snooper), 64'd0);
        cyc();
        chk("snp_back", 64'(ready_for_snooper), 64'd1);
        for (int p = 4; p <= 6; p++) begin
            wait_rdy("fwd_ready_drain", 2);
            fwd_read(0, pat(p, 0));
            fwd_release();
        end
        // Reacquired buffer previously held length 7; a single write at addr 1 must report 2.
        snp_pkt(7, 1, 1, 1'b0, 2);
        wait_rdy("cpu_ready_p7", 1);

        // Accept and reject together: accept wins, no count.
        cpu_acc = 1'b1;
        cpu_rej = 1'b1;
        fwd_len_q.push_back(LW'(2));
        cyc();
        cpu_acc = 1'b0;
        cpu_rej = 1'b0;
        chk("rej_acc_wins", 64'(rej_count), 64'd1);
        wait_rdy("fwd_ready_p7", 2);
        fwd_read(1, pat(7, 1));

        // Reject and forwarder done together: CPU's buffer re-enters FREE first.
        snp_pkt(8, 0, 3, 1'b0, 4);
        wait_rdy("cpu_ready_p8", 1);
        cpu_read(1, pat(8, 1));
        cpu_rej        = 1'b1;
        forwarder_done = 1'b1;
        cyc();
        cpu_rej        = 1'b0;
        forwarder_done = 1'b0;
        chk("rej_dual", 64'(rej_count), 64'd2);
        for (int p = 9; p <= 10; p++) begin
            snp_pkt(p, 0, 0, 1'b0, 1);
            wait_rdy("cpu_ready_filler", 1);
            cpu_reject();
        end
        // Unwritten word 1 still holds what the buffer's previous packet left there.
        snp_pkt(11, 0, 0, 1'b0, 1);
        wait_rdy("cpu_ready_p11", 1);
        cpu_read(1, pat(8, 1));
        cpu_reject();
        snp_pkt(12, 0, 0, 1'b0, 1);
        wait_rdy("cpu_ready_p12", 1);
        cpu_read(1, pat(7, 1));
        cpu_reject();
        chk("rej_total", 64'(rej_count), 64'd6);

        // All three agents busy with data on both read ports, then reset mid-packet.
        snp_pkt(13, 0, 0, 1'b0, 1);
        wait_rdy("cpu_ready_p13", 1);
        cpu_accept(1);
        wait_rdy("fwd_ready_p13", 2);
        snp_pkt(14, 0, 0, 1'b0, 1);
        wait_rdy("cpu_ready_p14", 1);
        wait_rdy("snp_ready_mid", 0);
        snooper_wr_en   = 1'b1;
        snooper_wr_addr = '0;
        snooper_wr_data = pat(15, 0);
        cyc();
        snooper_wr_en = 1'b0;
        cpu_read(0, pat(14, 0));
        fwd_read(0, pat(13, 0));
        cyc();
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (2) cyc();
        release_and_check("rel2");
        snp_pkt(15, 0, 5, 1'b0, 6);
        cyc();
        chk("cpu_ready_after_rst", 64'(ready_for_cpu), 64'd1);
        cpu_read(3, pat(15, 3));
        cyc();

        chk("cpu_len_leftover", 64'(cpu_len_q.size()), 64'd0);
        chk("fwd_len_leftover", 64'(fwd_len_q.size()), 64'd0);
        chk("cpu_rd_leftover", 64'(cpu_rd_q.size()), 64'd0);
        chk("fwd_rd_leftover", 64'(fwd_rd_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/packetmem_nbuf.md
Name: packetmem_nbuf

Overview:
- Parametrised successor to the three-buffer packet memory. Holds NUM_BUFS packet RAMs of DATA_WIDTH-bit words.
- Passes ownership snooper -> CPU -> forwarder through index queues, replacing the fixed three-way rotation. Packet order is preserved, and the snooper can fill extra buffers while the CPU or forwarder is stalled.
- Sits between the packet snooper, BPF CPU and forwarder. The CPU byte-read size adapter stays external and drives the word-addressed CPU port.

Parameters:
- ADDR_WIDTH, 10, word address width per buffer (depth 2^ADDR_WIDTH).
- DATA_WIDTH, 64, word width of every data port.
- NUM_BUFS, 4, number of buffers, 3..16.
- IDX_WIDTH, clog2(NUM_BUFS), buffer index width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- snooper_wr_addr  in  ADDR_WIDTH  write word address.
- snooper_wr_data  in  DATA_WIDTH  write data.
- snooper_wr_en  in  1  write strobe.
- snooper_done  in  1  1-cycle pulse, packet complete.
- ready_for_snooper  out  1  snooper holds a buffer.
- cpu_rd_addr  in  ADDR_WIDTH  read word address.
- cpu_rd_en  in  1  read strobe.
- cpu_rd_data  out  DATA_WIDTH  read data.
- cpu_acc  in  1  1-cycle pulse, accept: send to forwarder.
- cpu_rej  in  1  1-cycle pulse, reject: return to free pool.
- ready_for_cpu  out  1  CPU holds a buffer.
- len_to_cpu  out  ADDR_WIDTH+1  packet length in words.
- forwarder_rd_addr  in  ADDR_WIDTH  read word address.
- forwarder_rd_en  in  1  read strobe.
- forwarder_rd_data  out  DATA_WIDTH  read data.
- forwarder_done  in  1  1-cycle pulse, buffer drained.
- ready_for_forwarder  out  1  forwarder holds a buffer.
- len_to_forwarder  out  ADDR_WIDTH+1  packet length in words.
- rej_count  out  32  saturating count of accepted cpu_rej pulses.

Behaviour:
Queues and ownership
- Three index FIFOs, each NUM_BUFS deep: FREE, TO_CPU, TO_FWD.
- Each agent holds at most one buffer: a held index plus a valid bit; ready_* equals the valid bit.

Reset (rst_n low)
- All ready_* = 0, all rd_data = 0, all len = 0, rej_count = 0.
- FREE = {0,1,...,NUM_BUFS-1}; TO_CPU and TO_FWD empty; all per-buffer lengths 0.
- First edge after release: snooper pops buffer 0, so ready_for_snooper = 1 one cycle after release.
- Reset asserted mid-operation discards all state. RAM contents are don't-care.

Acquire
- Every edge, an agent with valid=0 and a non-empty source queue pops the head into its held register.
- Sources: snooper<-FREE, cpu<-TO_CPU, forwarder<-TO_FWD.
- Push and pop on one queue in the same cycle are both legal. An empty queue with a simultaneous push yields the pushed index on the next edge, not the same edge.

Release
- A release edge clears valid, so ready drops for at least one cycle; reacquire at earliest on the following edge.
- snooper_done: push index to TO_CPU.
- cpu_acc: push to TO_FWD.
- cpu_rej: push to FREE, clear that buffer's length, rej_count += 1, saturating at 2^32-1.
- forwarder_done: push to FREE, clear length.
- cpu_acc and cpu_rej in the same cycle: acc wins, rej ignored, no count.
- cpu_rej and forwarder_done in the same cycle: both pushed to FREE, CPU's index first.
- Any strobe or done pulse while the corresponding ready=0 is ignored.

Length
- On a snooper write, the held buffer's len <= max(len, snooper_wr_addr+1). Width ADDR_WIDTH+1, so a full buffer reports 2^ADDR_WIDTH.
- len_to_cpu and len_to_forwarder are registered copies of the held buffer's length; 0 when not ready.

Reads
- rd_en with ready=1: rd_data valid exactly 1 cycle later and held until the next accepted read.
- When the agent releases, its rd_data goes to 0 on the same edge as ready falls.
- Write and reads target distinct buffers by construction; no collision logic.

Queue capacity
- The total number of indices is conserved, so no queue can overflow. Verification asserts index conservation every cycle.

Test Plan:
- Reset release, NUM_BUFS=4 -> ready_for_snooper=1 at cycle 1 holding idx 0; CPU and forwarder not ready; rej_count=0.
- Snooper writes addrs 0..5, pulses done -> ready_for_cpu rises 2 cycles later; len_to_cpu=6; cpu_rd_en at addr 3 returns the word written at addr 3 one cycle later.
- Three packets filled while the CPU is held off -> CPU receives them in order idx 0,1,2; accept 0 and 2, reject 1 -> forwarder gets 0 then 2; rej_count=1.
- Forwarder stalled, NUM_BUFS=4, snooper keeps filling -> after 4 packets ready_for_snooper stays 0; one forwarder_done -> snooper ready again 1 cycle later, len of the reacquired buffer = 0.
- Same-cycle cpu_acc+cpu_rej -> buffer goes to forwarder, rej_count unchanged; same-cycle cpu_rej+forwarder_done -> FREE order is CPU idx then forwarder idx.
- rst_n asserted mid-packet with all agents busy -> all outputs 0 immediately (asynchronous); after release, state is identical to the first scenario.
